i2c_config_seq: RTL and testbench
=================================

I2C_CONFIG_SEQ -- requirements
Module: i2c_config_seq

Interface
REQ-001 SHALL have parameter RETRY_MAX, default 3, giving the number of re-attempts per entry after a NACKed write.
REQ-002 SHALL have parameter DELAY_UNIT, default 50000, giving clock cycles per delay unit (1 ms at 50 MHz).
REQ-003 SHALL have port clk  in  1  system clock; all logic is on the rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  in  1  one-cycle pulse that begins a configuration sequence.
REQ-006 SHALL have port lut_size  in  8  number of table entries (0..255).
REQ-007 SHALL have port lut_index  out  8  table entry address.
REQ-008 SHALL have port lut_data  in  32  entry {dev_addr[31:24], reg_addr[23:8], data[7:0]}, valid 1 cycle after lut_index changes.
REQ-009 SHALL have port i2c_write_req  out  1  write request to the I2C master.
REQ-010 SHALL have port i2c_write_req_ack  in  1  one-cycle write completion from the I2C master.
REQ-011 SHALL have port i2c_error  in  1  master NACK indication, valid in the i2c_write_req_ack cycle.
REQ-012 SHALL have ports i2c_slave_dev_addr  out  8, i2c_slave_reg_addr  out  16 and i2c_write_data  out  8, the latched entry fields.
REQ-013 SHALL have ports busy  out  1, done  out  1 (pulse), error  out  1 (sticky) and err_index  out  8 (failing entry).

Function
REQ-014 SHALL implement the states IDLE, FETCH, DECODE, WRITE, WAIT_ACK, DELAY, NEXT, DONE and FAIL.
REQ-015 IDLE: on start with lut_size==0 SHALL go to DONE; otherwise SHALL go to FETCH with lut_index=0, retry count=0 and error cleared.
REQ-016 start outside IDLE SHALL be ignored.
REQ-017 FETCH SHALL last exactly 1 cycle (table latency); DECODE SHALL register lut_data into the dev/reg/data outputs.
REQ-018 DECODE with dev_addr==8'hFF SHALL treat the entry as a delay entry: go to DELAY with reg_addr field as the unit count; a count of 0 SHALL go directly to NEXT.
REQ-019 DELAY SHALL last exactly units*DELAY_UNIT cycles (32-bit counter, no overflow for 16-bit units at default) and then go to NEXT.
REQ-020 Any other dev_addr SHALL go to WRITE.
REQ-021 WRITE SHALL set i2c_write_req=1 (registered) and go to WAIT_ACK.
REQ-022 i2c_write_req SHALL stay high until the i2c_write_req_ack cycle and SHALL be low from the following cycle.
REQ-023 On ack with i2c_error==0: SHALL go to NEXT and clear the retry count.
REQ-024 On ack with i2c_error==1 and retry count<RETRY_MAX: SHALL increment the retry count and return to WRITE after at least 2 idle cycles (the master's recovery); the outputs are unchanged.
REQ-025 On ack with i2c_error==1 and retry count==RETRY_MAX: SHALL go to FAIL.
REQ-026 NEXT: if lut_index==lut_size-1 SHALL go to DONE; otherwise lut_index+1 and go to FETCH.
REQ-027 lut_index SHALL never wrap past 255.
REQ-028 DONE SHALL pulse done for 1 cycle and return to IDLE.
REQ-029 FAIL SHALL set error=1, set err_index=lut_index, pulse done for 1 cycle and return to IDLE (the remaining entries are abandoned).
REQ-030 busy SHALL be 1 in every state except IDLE.
REQ-031 error and err_index SHALL hold until the next accepted start.
REQ-032 lut_size SHALL be sampled at start; later changes SHALL have no effect on the running sequence.
REQ-033 A spurious i2c_write_req_ack outside WAIT_ACK SHALL be ignored.

Reset
REQ-034 While rst is high, the state SHALL be IDLE and all outputs 0: i2c_write_req, busy, done, error, err_index, lut_index, dev/reg/data.
REQ-035 rst asserted mid-sequence (including while i2c_write_req is high) SHALL drop i2c_write_req asynchronously.
REQ-036 After release of rst, no request SHALL be issued until a new start.

Verification
REQ-037 Table {0x78,0x3008,0x82},{0x78,0x3103,0x03}, lut_size=2, master always ACKs -> two write requests in order with exact fields, done pulse, error=0, busy low afterwards.
REQ-038 lut_size=0, start -> done pulse within 2 cycles and no i2c_write_req.
REQ-039 Entry {0xFF,0x0002,x} with DELAY_UNIT=10 -> exactly 20 delay cycles between the adjacent writes.
REQ-040 Entry 1 NACKed 4 times, RETRY_MAX=3 -> 4 requests, error=1, err_index=1, done pulse, entry 2 never issued.
REQ-041 Entry NACKed once then ACKed -> 2 requests, sequence continues, error=0 at end.
REQ-042 rst during WAIT_ACK -> i2c_write_req=0 immediately; outputs at reset values; a new start replays from index 0.

Source files
------------

// File: rtl/i2c_config_seq.sv
// Walks a register-init table and issues one I2C write per entry, with NACK
// retries, 0xFF delay entries, a done pulse and a sticky error/err_index.
module i2c_config_seq #(
  parameter int RETRY_MAX  = 3,
  parameter int DELAY_UNIT = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  lut_size,
  output logic [7:0]  lut_index,
  input  logic [31:0] lut_data,
  output logic        i2c_write_req,
  input  logic        i2c_write_req_ack,
  input  logic        i2c_error,
  output logic [7:0]  i2c_slave_dev_addr,
  output logic [15:0] i2c_slave_reg_addr,
  output logic [7:0]  i2c_write_data,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [7:0]  err_index
);
  localparam int RW = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);

  // RECOVER gives the master its idle gap before a retried write.
  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, WRITE, WAIT_ACK, RECOVER, DELAY, NEXT, DONE, FAIL
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    idx_q, idx_d, size_q, size_d;
  logic [7:0]    dev_q, dev_d, dat_q, dat_d, eidx_q, eidx_d;
  logic [15:0]   reg_q, reg_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [31:0]   cnt_q, cnt_d;
  logic          req_q, req_d, err_q, err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      size_q  <= '0;
      dev_q   <= '0;
      reg_q   <= '0;
      dat_q   <= '0;
      eidx_q  <= '0;
      retry_q <= '0;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      size_q  <= size_d;
      dev_q   <= dev_d;
      reg_q   <= reg_d;
      dat_q   <= dat_d;
      eidx_q  <= eidx_d;
      retry_q <= retry_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    size_d  = size_q;
    dev_d   = dev_q;
    reg_d   = reg_q;
    dat_d   = dat_q;
    eidx_d  = eidx_q;
    retry_d = retry_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (start) begin
        size_d  = lut_size;
        idx_d   = '0;
        retry_d = '0;
        err_d   = 1'b0;
        eidx_d  = '0;
        state_d = (lut_size == 8'd0) ? DONE : FETCH;
      end
      FETCH:  state_d = DECODE;
      DECODE: begin
        dev_d = lut_data[31:24];
        reg_d = lut_data[23:8];
        dat_d = lut_data[7:0];
        if (lut_data[31:24] == 8'hFF) begin
          cnt_d   = 32'(lut_data[23:8]) * 32'(DELAY_UNIT);
          state_d = (lut_data[23:8] == 16'd0) ? NEXT : DELAY;
        end else begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        req_d   = 1'b1;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: if (i2c_write_req_ack) begin
        req_d = 1'b0;
        if (!i2c_error) begin
          retry_d = '0;
          state_d = NEXT;
        end else if (retry_q < RW'(RETRY_MAX)) begin
          retry_d = retry_q + RW'(1);
          state_d = RECOVER;
        end else begin
          // Flag the error now so it is already visible during the done pulse.
          err_d   = 1'b1;
          eidx_d  = idx_q;
          state_d = FAIL;
        end
      end
      RECOVER: state_d = WRITE;
      DELAY: begin
        cnt_d = cnt_q - 32'd1;
        if (cnt_q <= 32'd1) state_d = NEXT;
      end
      NEXT: begin
        if (idx_q == size_q - 8'd1) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = FETCH;
        end
      end
      DONE:    state_d = IDLE;
      FAIL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign lut_index          = idx_q;
  assign i2c_write_req      = req_q;
  assign i2c_slave_dev_addr = dev_q;
  assign i2c_slave_reg_addr = reg_q;
  assign i2c_write_data     = dat_q;
  assign busy               = (state_q != IDLE);
  assign done               = (state_q == DONE) || (state_q == FAIL);
  assign error              = err_q;
  assign err_index          = eidx_q;
endmodule

// File: tb/tb_i2c_config_seq.sv
// Directed bench: table of sequences against a ROM + I2C master model,
// plus hand sequences for delay timing, spurious ack and mid-write reset.
module tb_i2c_config_seq;
  localparam int RMAX = 3;

  logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [7:0]  lut_size = '0, lut_index;
  logic [31:0] lut_data = '0;
  logic        i2c_write_req, i2c_write_req_ack = 1'b0, i2c_error = 1'b0;
  logic [7:0]  dev, dat, err_index;
  logic [15:0] rga;
  logic        busy, done, error;

  i2c_config_seq #(.RETRY_MAX(RMAX), .DELAY_UNIT(10)) dut (
    .clk(clk), .rst(rst), .start(start), .lut_size(lut_size), .lut_index(lut_index),
    .lut_data(lut_data), .i2c_write_req(i2c_write_req), .i2c_write_req_ack(i2c_write_req_ack),
    .i2c_error(i2c_error), .i2c_slave_dev_addr(dev), .i2c_slave_reg_addr(rga),
    .i2c_write_data(dat), .busy(busy), .done(done), .error(error), .err_index(err_index)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  size;
    logic [15:0] mask;
    int          nreq;
    logic        err;
    logic [7:0]  eidx;
  } vec_t;

  logic [31:0] rom [16];
  logic [31:0] log_w [64], exp_w [32];
  int rise_c [64], ack_c [64];
  int cyc = 0, nreq = 0, base = 0, done_cnt = 0, exp_n = 0;
  int spur_cnt = 0, spur_seen = 0, wcnt = 0;
  logic [15:0] nack_mask = '0;
  bit in_req = 0;
  int nvec = 0, nerr = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (done) done_cnt <= done_cnt + 1;
  always @(negedge clk) lut_data = rom[lut_index[3:0]];

  // I2C master: acks the second low phase of a request; NACKs per nack_mask.
  always @(negedge clk) begin
    if (i2c_write_req_ack) begin
      i2c_write_req_ack = 1'b0;
      i2c_error = 1'b0;
    end else if (!i2c_write_req) begin
      in_req = 0;
      if (spur_cnt != spur_seen) begin
        spur_seen = spur_cnt;
        i2c_write_req_ack = 1'b1;
        i2c_error = 1'b1;
      end
    end else if (nreq < 64) begin
      if (!in_req) begin
        in_req = 1;
        wcnt = 0;
        rise_c[nreq] = cyc;
      end
      wcnt++;
      if (wcnt == 2) begin
        log_w[nreq] = {dev, rga, dat};
        ack_c[nreq] = cyc;
        i2c_error = nack_mask[(nreq - base) & 15];
        i2c_write_req_ack = 1'b1;
        nreq++;
        in_req = 0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Expected write stream: skip delay entries, repeat NACKed writes up to RMAX retries.
  function automatic void build_exp(input logic [7:0] size, input logic [15:0] mask);
    int r;
    bit stop;
    exp_n = 0;
    r = 0;
    stop = 0;
    for (int e = 0; e < int'(size) && !stop; e++) begin
      if (rom[e][31:24] == 8'hFF) continue;
      for (int k = 0; k <= RMAX; k++) begin
        exp_w[exp_n] = rom[e];
        exp_n++;
        if (!mask[r]) begin
          r++;
          break;
        end
        r++;
        if (k == RMAX) stop = 1;
      end
    end
  endfunction

  task automatic run_vec(input logic [7:0] size, input logic [15:0] mask, input int enreq,
                         input logic eerr, input logic [7:0] eidx);
    int b, d0, s, done_at;
    bit got;
    build_exp(size, mask);
    b = nreq;
    base = nreq;
    nack_mask = mask;
    d0 = done_cnt;
    @(negedge clk);
    lut_size = size;
    start = 1'b1;
    s = cyc;
    @(negedge clk);
    start = 1'b0;
    lut_size = 8'd9;
    if (size != 0) begin
      chk("busy_running", busy, 1);
      repeat (3) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    got = 0;
    done_at = 0;
    for (int t = 0; t < 3000 && !got; t++) begin
      if (done) begin
        got = 1;
        done_at = cyc;
      end else @(negedge clk);
    end
    chk("done_seen", got, 1);
    if (size == 0) chk("size0_done_fast", (done_at - s) <= 2, 1);
    repeat (3) @(negedge clk);
    chk("busy_after", busy, 0);
    chk("req_after", i2c_write_req, 0);
    chk("error", error, eerr);
    chk("err_index", err_index, eidx);
    chk("done_pulses", done_cnt - d0, 1);
    chk("nreq", nreq - b, enreq);
    for (int i = 0; i < exp_n && i < nreq - b; i++)
      chk($sformatf("fields[%0d]", i), log_w[b + i], exp_w[i]);
  endtask

  initial begin
    vec_t vt [6];
    int b, d0, nh;
    vt[0] = '{8'd2, 16'h0000, 2, 1'b0, 8'd0};  // two plain writes
    vt[1] = '{8'd0, 16'h0000, 0, 1'b0, 8'd0};  // empty table
    vt[2] = '{8'd2, 16'h0002, 3, 1'b0, 8'd0};  // entry 1 NACKed once
    vt[3] = '{8'd3, 16'h0000, 2, 1'b0, 8'd0};  // last entry is a delay
    vt[4] = '{8'd1, 16'h000F, 4, 1'b1, 8'd0};  // entry 0 exhausts retries
    vt[5] = '{8'd5, 16'h001E, 5, 1'b1, 8'd1};  // entry 1 fails, rest abandoned

    rom[0] = 32'h7830_0882;
    rom[1] = 32'h7831_0303;
    rom[2] = 32'hFF00_0200;
    rom[3] = 32'h7840_0055;
    rom[4] = 32'h3C12_34AA;
    for (int i = 5; i < 16; i++) rom[i] = 32'h5000_0000 | 32'(i);

    @(negedge clk);
    chk("rst_req", i2c_write_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_index", lut_index, 0);
    chk("rst_fields", {dev, rga, dat}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 6; v++)
      run_vec(vt[v].size, vt[v].mask, vt[v].nreq, vt[v].err, vt[v].eidx);

    // Sticky error survives idle time and a spurious (NACK) ack.
    d0 = done_cnt;
    b = nreq;
    repeat (5) @(negedge clk);
    spur_cnt++;
    repeat (4) @(negedge clk);
    chk("spur_busy", busy, 0);
    chk("spur_req_count", nreq - b, 0);
    chk("hold_error", error, 1);
    chk("hold_err_index", err_index, 1);
    chk("spur_no_done", done_cnt - d0, 0);

    // Delay entry: 2 units x 10 cycles adds 20 + NEXT/FETCH/DECODE to the gap.
    b = nreq;
    run_vec(8'd4, 16'h0000, 3, 1'b0, 8'd0);
    chk("gap_plain", rise_c[b + 1] - ack_c[b], 5);
    chk("gap_delay", rise_c[b + 2] - ack_c[b + 1], 28);

    b = nreq;
    run_vec(8'd2, 16'h0002, 3, 1'b0, 8'd0);
    chk("retry_gap_min2", (rise_c[b + 2] - ack_c[b + 1]) >= 3, 1);

    // Reset while the write request is outstanding.
    @(negedge clk);
    lut_size = 8'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t < 50 && !i2c_write_req; t++) @(negedge clk);
    chk("req_before_rst", i2c_write_req, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_req", i2c_write_req, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_done", done, 0);
    chk("rst_mid_error", {error, err_index}, 0);
    chk("rst_mid_index", lut_index, 0);
    chk("rst_mid_fields", {dev, rga, dat}, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    nh = 0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (i2c_write_req) nh++;
    end
    chk("no_req_after_rst", nh, 0);
    run_vec(8'd2, 16'h0000, 2, 1'b0, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
